// File: rtl/bist_ram_pkg.sv
// Shared types and constants for the BIST dual-port RAM.
// Holds the sequencer state encoding, the word-width helper and the legal read-latency range.
package bist_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic int word_width(input int lanes, input int lane_w);
        return lanes * lane_w;
    endfunction

    function automatic bit rd_lat_ok(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/bist_ram_core.sv
// Storage array with lane-masked write and a registered, read-first read port.
// The caller guarantees that both addresses are in range whenever the port enable is set.
module bist_ram_core
    import bist_ram_pkg::*;
#(
    parameter  int AW     = 4,
    parameter  int DEPTH  = 16,
    parameter  int LANE_W = 8,
    parameter  int LANES  = 1,
    localparam int W      = word_width(LANES, LANE_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [LANES-1:0] i_be,
    input  logic [AW-1:0]    i_waddr,
    input  logic [W-1:0]     i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [W-1:0]     o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (i_we && i_be[i]) begin
                r_mem[i_waddr][i*LANE_W +: LANE_W] <= i_wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    // Read register samples the pre-write word on a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bist_ram_dp.sv
// Simple-dual-port BIST RAM: zero-fill sequencer, range check, collision bypass and read pipeline
// wrapped around bist_ram_core.
module bist_ram_dp
    import bist_ram_pkg::*;
#(
    parameter  int AW          = 4,
    parameter  int DEPTH       = 16,
    parameter  int LANE_W      = 8,
    parameter  int LANES       = 1,
    parameter  int RD_LAT      = 1,
    parameter  int WRITE_FIRST = 0,
    localparam int W           = word_width(LANES, LANE_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_req,
    input  logic             wr_en,
    input  logic [LANES-1:0] wr_be,
    input  logic [AW-1:0]    wr_addr,
    input  logic [W-1:0]     wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [W-1:0]     rd_data,
    output logic             rd_valid,
    output logic             init_busy,
    output logic             addr_err
);

    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);
    localparam bit            TWO_STAGE = (RD_LAT >= RD_LAT_MAX);

    state_t         r_state;
    logic [AW-1:0]  r_cnt;
    logic           r_busy;

    logic           w_ready;
    logic           w_wr_acc;
    logic           w_rd_acc;
    logic           w_wr_oor;
    logic           w_rd_oor;
    logic           w_collide;

    logic             w_core_we;
    logic [LANES-1:0] w_core_be;
    logic [AW-1:0]    w_core_waddr;
    logic [W-1:0]     w_core_wdata;
    logic             w_core_re;
    logic [W-1:0]     w_core_rdata;

    logic             r_s1_valid;
    logic             r_s1_zero;
    logic             r_s1_byp;
    logic [W-1:0]     r_s1_wdata;
    logic [LANES-1:0] r_s1_be;
    logic             r_addr_err;
    logic [W-1:0]     w_s1_merged;
    logic [W-1:0]     w_s1_data;

    assign w_ready  = (r_state == ST_READY);
    assign w_wr_acc = wr_en & w_ready;
    assign w_rd_acc = rd_en & w_ready;

    if (DEPTH < (1 << AW)) begin : g_range
        assign w_wr_oor = (int'(wr_addr) >= DEPTH);
        assign w_rd_oor = (int'(rd_addr) >= DEPTH);
    end else begin : g_full
        assign w_wr_oor = 1'b0;
        assign w_rd_oor = 1'b0;
    end

    assign w_collide = (WRITE_FIRST != 0) && w_wr_acc && !w_wr_oor && (wr_addr == rd_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_READY;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (init_req) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // The clear sequencer owns the write port while zero-filling.
    assign w_core_we    = w_ready ? (w_wr_acc & ~w_wr_oor) : 1'b1;
    assign w_core_be    = w_ready ? wr_be   : '1;
    assign w_core_waddr = w_ready ? wr_addr : r_cnt;
    assign w_core_wdata = w_ready ? wr_data : '0;
    assign w_core_re    = w_rd_acc & ~w_rd_oor;

    bist_ram_core #(
        .AW     (AW),
        .DEPTH  (DEPTH),
        .LANE_W (LANE_W),
        .LANES  (LANES)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_core_we),
        .i_be    (w_core_be),
        .i_waddr (w_core_waddr),
        .i_wdata (w_core_wdata),
        .i_re    (w_core_re),
        .i_raddr (rd_addr),
        .o_rdata (w_core_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_byp   <= 1'b0;
            r_s1_wdata <= '0;
            r_s1_be    <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_s1_valid <= w_rd_acc;
            r_addr_err <= (w_wr_acc & w_wr_oor) | (w_rd_acc & w_rd_oor);
            if (w_rd_acc) begin
                r_s1_zero  <= w_rd_oor;
                r_s1_byp   <= w_collide;
                r_s1_wdata <= wr_data;
                r_s1_be    <= wr_be;
            end
        end
    end

    // Write-first collisions overlay the written lanes onto the old word read by the core.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_s1_merged[i*LANE_W +: LANE_W] = (r_s1_byp && r_s1_be[i]) ?
                                                 r_s1_wdata[i*LANE_W +: LANE_W] :
                                                 w_core_rdata[i*LANE_W +: LANE_W];
    end

    assign w_s1_data = r_s1_zero ? '0 : w_s1_merged;

    if (TWO_STAGE) begin : g_lat2
        logic         r_v2;
        logic [W-1:0] r_d2;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v2 <= 1'b0;
                r_d2 <= '0;
            end else begin
                r_v2 <= r_s1_valid;
                if (r_s1_valid) begin
                    r_d2 <= w_s1_data;
                end
            end
        end

        assign rd_valid = r_v2;
        assign rd_data  = r_d2;
    end else begin : g_lat1
        assign rd_valid = r_s1_valid;
        assign rd_data  = w_s1_data;
    end

    assign init_busy = r_busy;
    assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_bist_ram_dp.sv
// Scoreboard bench for bist_ram_dp: two instances (DEPTH 12 / RD_LAT 2 / write-first and
// DEPTH 16 / RD_LAT 1 / read-first) share one stimulus stream and a word-level reference model.
module tb_bist_ram_dp;

    localparam int AW     = 4;
    localparam int LANE_W = 8;
    localparam int LANES  = 2;
    localparam int W      = 16;

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             init_req = 1'b0;
    logic             wr_en = 1'b0;
    logic [LANES-1:0] wr_be = '0;
    logic [AW-1:0]    wr_addr = '0;
    logic [W-1:0]     wr_data = '0;
    logic             rd_en = 1'b0;
    logic [AW-1:0]    rd_addr = '0;

    logic [W-1:0] rdData0, rdData1;
    logic         rdValid0, rdValid1;
    logic         busy0, busy1;
    logic         err0, err1;

    int           depthOf [2] = '{12, 16};
    int           latOf   [2] = '{2, 1};
    int           wfOf    [2] = '{1, 0};

    logic [W-1:0] mem [2][16];
    int           busyLeft [2];
    logic         pendBusy [2];
    logic         pendErr  [2];
    logic         latBusy  [2];
    logic         latErr   [2];
    logic [W-1:0] lastExp  [2];
    exp_t         q0 [$];
    exp_t         q1 [$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bist_ram_dp #(
        .AW(AW), .DEPTH(12), .LANE_W(LANE_W), .LANES(LANES), .RD_LAT(2), .WRITE_FIRST(1)
    ) dutA (
        .clk(clk), .rst(rst), .init_req(init_req),
        .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rdData0), .rd_valid(rdValid0), .init_busy(busy0), .addr_err(err0)
    );

    bist_ram_dp #(
        .AW(AW), .DEPTH(16), .LANE_W(LANE_W), .LANES(LANES), .RD_LAT(1), .WRITE_FIRST(0)
    ) dutB (
        .clk(clk), .rst(rst), .init_req(init_req),
        .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rdData1), .rd_valid(rdValid1), .init_busy(busy1), .addr_err(err1)
    );

    function automatic logic [W-1:0] merge(input logic [W-1:0] oldW, input logic [W-1:0] newW,
                                           input logic [LANES-1:0] be);
        logic [W-1:0] mask;
        mask = {{LANE_W{be[1]}}, {LANE_W{be[0]}}};
        return (oldW & ~mask) | (newW & mask);
    endfunction

    task automatic check(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL inst%0d %s: got %h expected %h (cycle %0d)", k, name, act, exp, cyc);
        end
    endtask

    task automatic pushExp(input int k, input logic [W-1:0] d, input int due);
        exp_t e;
        e.data = d;
        e.due  = due;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic popFront(input int k);
        if (k == 0) q0.delete(0);
        else        q1.delete(0);
    endtask

    // One clock of stimulus; the reference model consumes the same request at the same time.
    task automatic applyStimulus(input logic ir, input logic we, input logic [LANES-1:0] be,
                                 input logic [AW-1:0] wa, input logic [W-1:0] wd,
                                 input logic re, input logic [AW-1:0] ra);
        logic [W-1:0] rv;
        init_req = ir; wr_en = we; wr_be = be; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
        for (int k = 0; k < 2; k++) begin
            pendErr[k] = 1'b0;
            if (busyLeft[k] > 0) begin
                busyLeft[k]--;
                pendBusy[k] = (busyLeft[k] > 0);
            end else begin
                if (re) begin
                    if (int'(ra) >= depthOf[k]) begin
                        rv = '0;
                        pendErr[k] = 1'b1;
                    end else if (we && (wa == ra) && (wfOf[k] != 0)) begin
                        rv = merge(mem[k][ra], wd, be);
                    end else begin
                        rv = mem[k][ra];
                    end
                    pushExp(k, rv, cyc + latOf[k]);
                end
                if (we) begin
                    if (int'(wa) >= depthOf[k]) pendErr[k] = 1'b1;
                    else                        mem[k][wa] = merge(mem[k][wa], wd, be);
                end
                if (ir) begin
                    for (int j = 0; j < 16; j++) mem[k][j] = '0;
                    busyLeft[k] = depthOf[k];
                    pendBusy[k] = 1'b1;
                end else begin
                    pendBusy[k] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, '0, 0, '0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            lastExp[k] = '0;
            for (int j = 0; j < 16; j++) mem[k][j] = '0;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            busyLeft[k] = depthOf[k];
            pendBusy[k] = 1'b1;
            pendErr[k]  = 1'b0;
        end
    endtask

    task automatic checkOutput(input int k, input logic v, input logic [W-1:0] d,
                               input logic b, input logic e);
        exp_t f;
        bit   have;
        if (rst) begin
            check(k, "reset_rd_valid", 32'(v), 0);
            check(k, "reset_rd_data", 32'(d), 0);
            check(k, "reset_init_busy", 32'(b), 1);
            check(k, "reset_addr_err", 32'(e), 0);
            return;
        end
        check(k, "init_busy", 32'(b), 32'(latBusy[k]));
        check(k, "addr_err", 32'(e), 32'(latErr[k]));
        if (k == 0) have = (q0.size() != 0);
        else        have = (q1.size() != 0);
        if (have) begin
            if (k == 0) f = q0[0];
            else        f = q1[0];
        end
        if (v) begin
            if (!have) begin
                check(k, "rd_valid_spurious", 32'(v), 0);
            end else begin
                popFront(k);
                check(k, "rd_latency", cyc, f.due);
                check(k, "rd_data", 32'(d), 32'(f.data));
                lastExp[k] = f.data;
            end
        end else begin
            if (have && (f.due <= cyc)) begin
                check(k, "rd_valid_missing", 32'(v), 1);
                popFront(k);
            end
            check(k, "rd_hold", 32'(d), 32'(lastExp[k]));
        end
    endtask

    // Monitor: latch what the model expects at each edge, compare on the following falling edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                latBusy[k] = rst ? 1'b1 : pendBusy[k];
                latErr[k]  = rst ? 1'b0 : pendErr[k];
            end
            @(negedge clk);
            checkOutput(0, rdValid0, rdData0, busy0, err0);
            checkOutput(1, rdValid1, rdData1, busy1, err1);
        end
    end

    initial begin
        #2;
        $display("[TB] start");
        doReset();

        // Zero-fill window, then every word reads back as zero.
        idle(18);
        for (int a = 0; a < 16; a++) applyStimulus(0, 0, '0, '0, '0, 1, 4'(a));
        idle(3);

        // Lane-masked writes.
        applyStimulus(0, 1, 2'b11, 4'd3, 16'hABCD, 0, '0);
        applyStimulus(0, 1, 2'b01, 4'd3, 16'h1234, 0, '0);
        applyStimulus(0, 1, 2'b00, 4'd3, 16'hFFFF, 0, '0);
        applyStimulus(0, 0, '0, '0, '0, 1, 4'd3);
        idle(3);

        // Same-address collision, then a plain read of the committed word.
        applyStimulus(0, 1, 2'b11, 4'd5, 16'h0011, 0, '0);
        applyStimulus(0, 1, 2'b11, 4'd5, 16'h0022, 1, 4'd5);
        applyStimulus(0, 0, '0, '0, '0, 1, 4'd5);
        applyStimulus(0, 1, 2'b10, 4'd5, 16'h3300, 1, 4'd5);
        idle(3);

        // Out-of-range accesses on the 12-word instance.
        applyStimulus(0, 1, 2'b11, 4'd13, 16'h0007, 0, '0);
        idle(2);
        applyStimulus(0, 0, '0, '0, '0, 1, 4'd13);
        idle(2);
        applyStimulus(0, 1, 2'b11, 4'd14, 16'h5A5A, 1, 4'd15);
        idle(2);

        // Back-to-back reads.
        applyStimulus(0, 1, 2'b11, 4'd1, 16'h0101, 0, '0);
        applyStimulus(0, 1, 2'b11, 4'd2, 16'h0202, 0, '0);
        applyStimulus(0, 0, '0, '0, '0, 1, 4'd1);
        applyStimulus(0, 0, '0, '0, '0, 1, 4'd2);
        applyStimulus(0, 0, '0, '0, '0, 1, 4'd3);
        idle(3);
        for (int a = 0; a < 16; a++) applyStimulus(0, 0, '0, '0, '0, 1, 4'(a));
        idle(3);

        // Reset part-way through the zero-fill, then a full fill and an init_req clear.
        doReset();
        idle(7);
        doReset();
        idle(18);
        for (int a = 0; a < 16; a++) applyStimulus(0, 1, 2'b11, 4'(a), 16'(16'hC000 + a), 0, '0);
        applyStimulus(0, 0, '0, '0, '0, 1, 4'd9);
        applyStimulus(1, 0, '0, '0, '0, 0, '0);
        applyStimulus(1, 1, 2'b11, 4'd2, 16'hBEEF, 1, 4'd2);
        idle(17);
        for (int a = 0; a < 16; a++) applyStimulus(0, 0, '0, '0, '0, 1, 4'(a));
        idle(3);

        // Randomized traffic, with a bias towards same-address collisions.
        for (int i = 0; i < 400; i++) begin
            logic             ir, we, re;
            logic [LANES-1:0] be;
            logic [AW-1:0]    wa, ra;
            logic [W-1:0]     wd;
            ir = ($urandom_range(0, 79) == 0);
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            be = 2'($urandom_range(0, 3));
            wa = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            wd = 16'($urandom);
            applyStimulus(ir, we, be, wa, wd, re, ra);
        end
        idle(20);
        for (int a = 0; a < 16; a++) applyStimulus(0, 0, '0, '0, '0, 1, 4'(a));
        idle(5);

        check(0, "scoreboard_drained", q0.size(), 0);
        check(1, "scoreboard_drained", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
